// File: rtl/lane_word_tx.sv
// Lane transmitter: serializes one WORD_W-bit word MSB-first onto a LANE_W-bit lane,
// optionally followed by one XOR-fold parity beat, with sof/eof framing and backpressure.
module lane_word_tx #(
  parameter int WORD_W    = 24,
  parameter int LANE_W    = 2,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              lane_valid,
  input  logic              lane_ready,
  output logic [LANE_W-1:0] lane_data,
  output logic              lane_sof,
  output logic              lane_eof
);

  localparam int NBEATS = WORD_W / LANE_W;
  localparam int CNT_W  = $clog2(NBEATS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);
  localparam bit PAR_ON    = (PARITY_EN != 0);
  // A single-beat frame without parity is both first and last beat.
  localparam bit EOF_FIRST = !PAR_ON && (NBEATS == 1);

  if (LANE_W < 1) begin : g_bad_lane
    $error("lane_word_tx: LANE_W must be >= 1");
  end
  if (WORD_W % LANE_W != 0) begin : g_bad_word
    $error("lane_word_tx: WORD_W must be a multiple of LANE_W");
  end

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  state_t              state;
  logic [WORD_W-1:0]   shift;
  logic [CNT_W-1:0]    count;
  logic [LANE_W-1:0]   parity;

  logic [WORD_W-1:0]   shift_nxt;
  logic [LANE_W-1:0]   par_nxt;
  logic [CNT_W-1:0]    cnt_nxt;

  always_comb begin
    shift_nxt = shift << LANE_W;
    par_nxt   = parity ^ lane_data;
    cnt_nxt   = count + 1'b1;
  end

  // Outputs are registered: each transition precomputes the beat shown next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      count      <= '0;
      parity     <= '0;
      in_ready   <= 1'b1;
      lane_valid <= 1'b0;
      lane_data  <= '0;
      lane_sof   <= 1'b0;
      lane_eof   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state      <= DATA;
            shift      <= in_data;
            count      <= '0;
            parity     <= '0;
            in_ready   <= 1'b0;
            lane_valid <= 1'b1;
            lane_data  <= in_data[WORD_W-1 -: LANE_W];
            lane_sof   <= 1'b1;
            lane_eof   <= EOF_FIRST;
          end
        end
        DATA: begin
          if (lane_valid && lane_ready) begin
            shift  <= shift_nxt;
            parity <= par_nxt;
            count  <= cnt_nxt;
            if (count == LAST) begin
              if (PAR_ON) begin
                state     <= PAR;
                lane_data <= par_nxt;
                lane_sof  <= 1'b0;
                lane_eof  <= 1'b1;
              end else begin
                state      <= IDLE;
                in_ready   <= 1'b1;
                lane_valid <= 1'b0;
                lane_data  <= '0;
                lane_sof   <= 1'b0;
                lane_eof   <= 1'b0;
              end
            end else begin
              lane_data <= shift_nxt[WORD_W-1 -: LANE_W];
              lane_sof  <= 1'b0;
              lane_eof  <= !PAR_ON && (cnt_nxt == LAST);
            end
          end
        end
        PAR: begin
          if (lane_valid && lane_ready) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            lane_valid <= 1'b0;
            lane_data  <= '0;
            lane_sof   <= 1'b0;
            lane_eof   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_word_tx.sv
// Bench for lane_word_tx: two instances (parity on / off) checked every cycle against
// a beat-list model, plus literal expectations on the received frames.
module tb_lane_word_tx;
  localparam int WW = 24;
  localparam int LW = 2;
  localparam int NB = WW / LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid   [2];
  logic [WW-1:0] in_data    [2];
  logic          lane_ready [2];
  logic          in_ready   [2];
  logic          lane_valid [2];
  logic [LW-1:0] lane_data  [2];
  logic          lane_sof   [2];
  logic          lane_eof   [2];

  always #5 clk = ~clk;

  lane_word_tx #(.WORD_W(WW), .LANE_W(LW), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .lane_valid(lane_valid[0]), .lane_ready(lane_ready[0]),
    .lane_data(lane_data[0]), .lane_sof(lane_sof[0]), .lane_eof(lane_eof[0]));

  lane_word_tx #(.WORD_W(WW), .LANE_W(LW), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .lane_valid(lane_valid[1]), .lane_ready(lane_ready[1]),
    .lane_data(lane_data[1]), .lane_sof(lane_sof[1]), .lane_eof(lane_eof[1]));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int cyc = 0;

  // Model: the current frame as a list of beats and a position within it.
  logic [LW-1:0] m_beat [2][0:15];
  int            m_len  [2] = '{0, 0};
  int            m_pos  [2] = '{0, 0};
  logic [LW-1:0] par;

  // Received beats, for literal checks.
  logic [LW-1:0] rxd [2][0:63];
  logic          rxs [2][0:63];
  logic          rxe [2][0:63];
  int            rxt [2][0:63];
  int            rxn [2] = '{0, 0};
  int            lowcnt [2] = '{0, 0};

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_len[k] = 0;
        m_pos[k] = 0;
      end else if (m_pos[k] >= m_len[k]) begin
        if (in_valid[k]) begin
          par = '0;
          for (int i = 0; i < NB; i++) begin
            m_beat[k][i] = LW'(in_data[k] >> (WW - LW * (i + 1)));
            par ^= m_beat[k][i];
          end
          m_beat[k][NB] = par;
          m_len[k] = NB + k;
          m_pos[k] = 0;
        end
      end else if (lane_ready[k]) begin
        m_pos[k]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit busy;
        busy = (m_pos[k] < m_len[k]);
        chk("in_ready", k, 32'(in_ready[k]), 32'(!busy));
        chk("lane_valid", k, 32'(lane_valid[k]), 32'(busy));
        if (busy) begin
          chk("lane_data", k, 32'(lane_data[k]), 32'(m_beat[k][m_pos[k]]));
          chk("lane_sof", k, 32'(lane_sof[k]), 32'(m_pos[k] == 0));
          chk("lane_eof", k, 32'(lane_eof[k]), 32'(m_pos[k] == m_len[k] - 1));
        end
        if (in_ready[k] === 1'b0) lowcnt[k]++;
        if (!rst && lane_valid[k] === 1'b1 && lane_ready[k] && rxn[k] < 64) begin
          rxd[k][rxn[k]] = lane_data[k];
          rxs[k][rxn[k]] = lane_sof[k];
          rxe[k][rxn[k]] = lane_eof[k];
          rxt[k][rxn[k]] = cyc;
          rxn[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx(input int k);
    rxn[k] = 0;
    lowcnt[k] = 0;
  endtask

  task automatic send(input int k, input logic [WW-1:0] w);
    bit acc;
    bit done;
    done = 0;
    in_valid[k] = 1'b1;
    in_data[k] = w;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      acc = (in_ready[k] === 1'b1);
      tick();
      if (acc) done = 1;
    end
    in_valid[k] = 1'b0;
    if (!done) chk("send_timeout", k, 32'd0, 32'd1);
  endtask

  task automatic wait_beats(input int k, input int n);
    for (int t = 0; t < 200 && rxn[k] < n; t++) tick();
    chk("beat_count_timeout", k, 32'(rxn[k] >= n), 32'd1);
  endtask

  function automatic logic [WW-1:0] word_at(input int k, input int s);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < NB; i++) w = {w[WW-LW-1:0], rxd[k][s + i]};
    return w;
  endfunction

  function automatic int count_flags(input int k, input bit eof_sel);
    int c;
    c = 0;
    for (int i = 0; i < rxn[k]; i++) c += eof_sel ? int'(rxe[k][i]) : int'(rxs[k][i]);
    return c;
  endfunction

  logic [3:0] bp_pat;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      in_data[k] = '0;
      lane_ready[k] = 1'b1;
    end
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_in_ready", k, 32'(in_ready[k]), 32'd1);
      chk("reset_lane_valid", k, 32'(lane_valid[k]), 32'd0);
      chk("reset_lane_data", k, 32'(lane_data[k]), 32'd0);
      chk("reset_sof_eof", k, {30'd0, lane_sof[k], lane_eof[k]}, 32'd0);
    end
    tick();
    chk_en = 1;
    rst = 1'b0;
    tick();

    // Single word 000001 with parity.
    clear_rx(1);
    send(1, 24'h000001);
    wait_beats(1, 13);
    tick(); tick();
    chk("t1_nbeats", 1, 32'(rxn[1]), 32'd13);
    chk("t1_word", 1, 32'(word_at(1, 0)), 32'h000001);
    chk("t1_last_data", 1, 32'(rxd[1][11]), 32'd1);
    chk("t1_parity", 1, 32'(rxd[1][12]), 32'd1);
    chk("t1_eof_par", 1, 32'(rxe[1][12]), 32'd1);
    chk("t1_sof0", 1, 32'(rxs[1][0]), 32'd1);
    chk("t1_sof_count", 1, 32'(count_flags(1, 0)), 32'd1);
    chk("t1_ready_low", 1, 32'(lowcnt[1]), 32'd13);

    // A5C3F0 with parity.
    clear_rx(1);
    send(1, 24'hA5C3F0);
    wait_beats(1, 13);
    tick();
    chk("t2_word", 1, 32'(word_at(1, 0)), 32'hA5C3F0);
    chk("t2_beat0", 1, 32'(rxd[1][0]), 32'd2);
    chk("t2_beat7", 1, 32'(rxd[1][7]), 32'd3);
    chk("t2_parity", 1, 32'(rxd[1][12]), 32'd0);

    // FFFFFF without parity.
    clear_rx(0);
    send(0, 24'hFFFFFF);
    wait_beats(0, 12);
    tick(); tick();
    chk("t3_nbeats", 0, 32'(rxn[0]), 32'd12);
    chk("t3_word", 0, 32'(word_at(0, 0)), 32'hFFFFFF);
    chk("t3_eof11", 0, 32'(rxe[0][11]), 32'd1);
    chk("t3_eof_count", 0, 32'(count_flags(0, 1)), 32'd1);
    chk("t3_ready_low", 0, 32'(lowcnt[0]), 32'd12);

    // Backpressure with in_valid pulses mid-frame.
    clear_rx(1);
    send(1, 24'hA5C3F0);
    bp_pat = 4'b1001;
    for (int t = 0; t < 200 && rxn[1] < 13; t++) begin
      lane_ready[1] = bp_pat[3 - (t % 4)];
      in_valid[1] = (t % 5 == 2);
      in_data[1] = 24'h123456;
      tick();
    end
    in_valid[1] = 1'b0;
    lane_ready[1] = 1'b1;
    tick(); tick(); tick();
    chk("t4_nbeats", 1, 32'(rxn[1]), 32'd13);
    chk("t4_word", 1, 32'(word_at(1, 0)), 32'hA5C3F0);
    chk("t4_parity", 1, 32'(rxd[1][12]), 32'd0);
    chk("t4_idle_after", 1, 32'(in_ready[1]), 32'd1);

    // Reset during beat 5.
    clear_rx(1);
    send(1, 24'hFFF000);
    wait_beats(1, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_rst", 1, 32'(lane_valid[1]), 32'd0);
    chk("t5_ready_after_rst", 1, 32'(in_ready[1]), 32'd1);
    chk("t5_no_eof", 1, 32'(count_flags(1, 1)), 32'd0);
    tick();
    clear_rx(1);
    send(1, 24'h000001);
    wait_beats(1, 13);
    tick();
    chk("t5_sof0", 1, 32'(rxs[1][0]), 32'd1);
    chk("t5_word", 1, 32'(word_at(1, 0)), 32'h000001);
    chk("t5_parity", 1, 32'(rxd[1][12]), 32'd1);

    // Back-to-back frames with in_valid held high.
    clear_rx(1);
    begin
      int nacc;
      bit acc;
      nacc = 0;
      in_valid[1] = 1'b1;
      in_data[1] = 24'h3C5A96;
      for (int t = 0; t < 100 && nacc < 2; t++) begin
        @(negedge clk);
        acc = (in_ready[1] === 1'b1);
        tick();
        if (acc) begin
          nacc++;
          in_data[1] = 24'h0F0F0E;
        end
      end
      in_valid[1] = 1'b0;
      chk("t6_accepts", 1, 32'(nacc), 32'd2);
    end
    wait_beats(1, 26);
    tick(); tick();
    chk("t6_nbeats", 1, 32'(rxn[1]), 32'd26);
    chk("t6_word1", 1, 32'(word_at(1, 0)), 32'h3C5A96);
    chk("t6_par1", 1, 32'(rxd[1][12]), 32'd0);
    chk("t6_word2", 1, 32'(word_at(1, 13)), 32'h0F0F0E);
    chk("t6_par2", 1, 32'(rxd[1][25]), 32'd1);
    chk("t6_sof2", 1, 32'(rxs[1][13]), 32'd1);
    chk("t6_gap", 1, 32'(rxt[1][13] - rxt[1][12]), 32'd2);
    chk("t6_eof_count", 1, 32'(count_flags(1, 1)), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lane_word_tx.md
Name: lane_word_tx

Overview:
- Transmitter side of the narrow lane interface; the existing lane receivers consume its output.
- Accepts one wide packed word per valid/ready handshake and serializes it MSB-first onto a LANE_W-bit lane in WORD_W/LANE_W beats.
- Optionally appends one XOR-fold parity beat.
- Marks frame boundaries with sof/eof and honours lane backpressure.

Parameters:
- WORD_W, 24, width of the parallel input word (default matches a [2:4][0:0][3:2][1:4] packed element); must be a multiple of LANE_W.
- LANE_W, 2, lane width in bits; must be >= 1.
- PARITY_EN, 1, 1 = append one parity beat after the data beats; 0 = data beats only.

Ports:
- clk, input, 1, the single clock; all state updates on posedge clk.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_data holds a word to send.
- in_ready, output, 1, block can accept a word this cycle.
- in_data, input, WORD_W, parallel word; bit WORD_W-1 is sent first.
- lane_valid, output, 1, lane_data holds a beat.
- lane_ready, input, 1, downstream accepts the beat this cycle.
- lane_data, output, LANE_W, current beat.
- lane_sof, output, 1, current beat is the first beat of a frame.
- lane_eof, output, 1, current beat is the last beat of a frame (parity beat when PARITY_EN=1).

Behaviour:
- NBEATS = WORD_W/LANE_W.
- Beat counter width is clog2(NBEATS+1).
- Elaboration error if WORD_W % LANE_W != 0.
- Reset (rst=1 at posedge) puts the FSM in IDLE, clears the shift register, beat counter and parity accumulator to 0, and drives these values:
  - in_ready=1 from the first cycle after reset.
  - lane_valid=0, lane_data=0, lane_sof=0, lane_eof=0.
- States: IDLE, DATA, PAR.
- IDLE:
  - in_ready=1, lane_valid=0.
  - On in_valid&in_ready: load the shift register with in_data, set count=0, clear parity, go to DATA.
  - lane_valid rises the cycle after acceptance (1-cycle latency).
- DATA:
  - in_ready=0, lane_valid=1.
  - lane_data = shift[WORD_W-1 -: LANE_W]; lane_sof=(count==0).
  - On lane_valid&lane_ready:
    - Shift left by LANE_W.
    - parity ^= lane_data.
    - count++.
  - When the handshake is on count==NBEATS-1:
    - go to PAR if PARITY_EN=1;
    - otherwise go to IDLE.
  - lane_eof=(count==NBEATS-1) only when PARITY_EN=0.
- PAR:
  - lane_valid=1, lane_data=parity accumulator (XOR of all data beats), lane_sof=0, lane_eof=1.
  - On handshake go to IDLE.
- Backpressure: while lane_valid=1 and lane_ready=0, lane_data, lane_sof, lane_eof and state are held stable.
- lane_valid never drops without a handshake, except on reset.
- Input words are not queued. in_ready=0 for the whole frame; in_valid is ignored outside IDLE and no word is lost.
- Minimum frame period is NBEATS+PARITY_EN+1 cycles (one IDLE bubble between frames).
- Degenerate NBEATS=1: the single beat has lane_sof=1; it also has lane_eof=1 when PARITY_EN=0.
- Reset mid-frame aborts the frame:
  - lane_valid=0 the cycle after rst.
  - No eof is emitted.
  - The next accepted word starts a fresh frame with sof.
- rst takes priority over all handshakes in the same cycle.
- Outputs are registered or decoded from registers only; no combinational path from in_valid or lane_ready to lane_data.
- lane_valid does not depend on lane_ready.

Test Plan:
- Default params, lane_ready=1, send in_data=24'h000001:
  - 12 beats: eleven beats of 2'b00, then 2'b01.
  - Parity beat 2'b01 with eof=1.
  - sof only on beat 0.
  - in_ready low for 13 cycles, high again the next cycle.
- in_data=24'hA5C3F0:
  - beats 10,10,01,01,11,00,00,11,11,11,00,00;
  - parity beat 00.
- in_data=24'hFFFFFF with PARITY_EN=0:
  - 12 beats of 2'b11;
  - eof on beat 11, no parity beat;
  - in_ready returns one cycle after that beat is accepted.
- Backpressure: toggle lane_ready 1,0,0,1,... during 24'hA5C3F0.
  - Each beat is held stable while ready=0.
  - Received sequence is identical to the previous test.
  - in_valid pulses mid-frame are not accepted.
- Assert rst during beat 5 of a frame:
  - next cycle lane_valid=0, in_ready=1.
  - A following word 24'h000001 produces a clean frame with sof on beat 0 and parity 01.
- Back-to-back: hold in_valid=1 with two words.
  - Exactly one IDLE cycle between the eof beat and the next sof beat.
  - Both frames are correct.
